nonce_sched: RTL and testbench

// - Sequences the SHA-256d mining pipeline: issues nonces from a programmed range into the W_start stage,

---
 rtl/nonce_sched.sv | 155 +++++++++++++++
 tb/tb_nonce_sched.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_sched.sv
// nonce_sched: issues nonces into the SHA-256d pipeline, tracks in-flight work, checks difficulty.
// Optional NONCE_SCHED_STATS_EN adds the hash_cnt result counter port.
`ifndef WORD_S
`define WORD_S [31:0]
`endif
`ifndef H_SIZE
`define H_SIZE 256
`endif
`ifndef WARR_S
`define WARR_S [511:0]
`endif
`ifndef DELAY
`define DELAY 1
`endif

module nonce_sched #(
  parameter int ISSUE_GAP    = `DELAY,
  parameter int MAX_INFLIGHT = 8,
  parameter int ZERO_BITS    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic `WORD_S       nonce_first,
  input  logic `WORD_S       nonce_last,
  input  logic `WARR_S       W_cfg,
  input  logic [`H_SIZE-1:0] H_cfg,
  output logic               pipe_en,
  output logic `WORD_S       pipe_nonce,
  output logic `WARR_S       pipe_W,
  output logic [`H_SIZE-1:0] pipe_H,
  input  logic               res_valid,
  input  logic [`H_SIZE-1:0] res_hash,
  input  logic `WORD_S       res_nonce,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic `WORD_S       golden_nonce,
  output logic               aborted
`ifdef NONCE_SCHED_STATS_EN
  ,
  output logic `WORD_S       hash_cnt
`endif
);

  localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [GW-1:0] GAP_RLD = GW'(ISSUE_GAP - 1);
  localparam logic [IW-1:0] MAX_I = IW'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic `WORD_S  nonce;
  logic `WORD_S  last;
  logic [GW-1:0] gap;
  logic [IW-1:0] inflight;
  logic          take;
  logic          issue;
  logic          accept;
  logic          hit;
  logic          last_issue;

  assign busy       = (state == RUN) || (state == DRAIN);
  assign take       = start && ((state == IDLE) || (state == DONE));
  assign issue      = (state == RUN) && (gap == '0) && (inflight < MAX_I);
  assign accept     = res_valid && busy && (inflight != '0);
  assign hit        = accept && !found &&
                      (res_hash[`H_SIZE-1 -: ZERO_BITS] == '0);
  assign last_issue = issue && (nonce == last);
  assign pipe_en    = issue;
  assign pipe_nonce = nonce;

  // Only the leading ZERO_BITS of the hash matter for the difficulty test.
  if (ZERO_BITS < `H_SIZE) begin : g_low
    logic unused_low;
    assign unused_low = ^res_hash[`H_SIZE-ZERO_BITS-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (take) state_nxt = RUN;
      RUN:        if (last_issue || hit || abort) state_nxt = DRAIN;
      DRAIN:      if (inflight == '0) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nonce        <= '0;
      last         <= '0;
      gap          <= '0;
      pipe_W       <= '0;
      pipe_H       <= '0;
      found        <= 1'b0;
      golden_nonce <= '0;
      aborted      <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= (state == DRAIN) && (state_nxt == DONE);
      if (take) begin
        nonce        <= nonce_first;
        last         <= nonce_last;
        gap          <= '0;
        pipe_W       <= W_cfg;
        pipe_H       <= H_cfg;
        found        <= 1'b0;
        golden_nonce <= '0;
        aborted      <= 1'b0;
      end else begin
        if (issue) begin
          nonce <= nonce + 32'd1;
          gap   <= GAP_RLD;
        end else if (gap != '0) begin
          gap <= gap - GW'(1);
        end
        if (hit) begin
          found        <= 1'b1;
          golden_nonce <= res_nonce;
        end
        if (abort && busy) aborted <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 inflight <= '0;
    else if (issue && !accept) inflight <= inflight + IW'(1);
    else if (!issue && accept) inflight <= inflight - IW'(1);
  end

`ifdef NONCE_SCHED_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           hash_cnt <= '0;
    else if (take)                       hash_cnt <= '0;
    else if (accept && hash_cnt != '1)   hash_cnt <= hash_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_nonce_sched.sv
// tb_nonce_sched: random and directed jobs against a queue-based model of nonce_sched.
// Checks every cycle; NONCE_SCHED_STATS_EN also checks hash_cnt.
module tb_nonce_sched;
  localparam int GAP  = 4;
  localparam int MAXF = 4;
  localparam int ZB   = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         abort;
  logic [31:0]  nonce_first;
  logic [31:0]  nonce_last;
  logic [511:0] W_cfg;
  logic [255:0] H_cfg;
  logic         pipe_en;
  logic [31:0]  pipe_nonce;
  logic [511:0] pipe_W;
  logic [255:0] pipe_H;
  logic         res_valid;
  logic [255:0] res_hash;
  logic [31:0]  res_nonce;
  logic         busy;
  logic         done;
  logic         found;
  logic [31:0]  golden_nonce;
  logic         aborted;
`ifdef NONCE_SCHED_STATS_EN
  logic [31:0]  hash_cnt;
`endif

  nonce_sched #(
    .ISSUE_GAP(GAP),
    .MAX_INFLIGHT(MAXF),
    .ZERO_BITS(ZB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .nonce_first(nonce_first),
    .nonce_last(nonce_last),
    .W_cfg(W_cfg),
    .H_cfg(H_cfg),
    .pipe_en(pipe_en),
    .pipe_nonce(pipe_nonce),
    .pipe_W(pipe_W),
    .pipe_H(pipe_H),
    .res_valid(res_valid),
    .res_hash(res_hash),
    .res_nonce(res_nonce),
    .busy(busy),
    .done(done),
    .found(found),
    .golden_nonce(golden_nonce),
    .aborted(aborted)
`ifdef NONCE_SCHED_STATS_EN
    ,
    .hash_cnt(hash_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // model: 0 idle, 1 run, 2 drain, 3 done
  int           m_state;
  logic [31:0]  m_next;
  longint       m_left;
  int           m_last_iss;
  logic         m_found;
  logic         m_aborted;
  logic         m_done;
  logic [31:0]  m_golden;
  logic [511:0] m_W;
  logic [255:0] m_H;
  longint       m_cnt;
  int           start_cyc;

  int          iq_c[$];
  logic [31:0] iq_n[$];
  int          log_c[$];
  logic [31:0] log_n[$];

  int          allow;
  int          lat;
  int          rthr;
  logic        stray;
  logic        hit_on;
  logic [31:0] tgt1;
  logic [31:0] tgt2;

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [255:0] hashf(input logic [31:0] n);
    if (hit_on && (n == tgt1 || n == tgt2))
      return {8'h00, 8'hFF, {7{n}}, 16'h0};
    return {8'h01, {7{~n}}, 24'h0};
  endfunction

  function automatic bit exp_en();
    return m_state == 1 && (cyc - m_last_iss) >= GAP && iq_n.size() < MAXF;
  endfunction

  task automatic model_reset();
    m_state = 0; m_next = '0; m_left = 0; m_last_iss = -1000;
    m_found = 0; m_aborted = 0; m_done = 0; m_golden = '0;
    m_W = '0; m_H = '0; m_cnt = 0;
    iq_c.delete(); iq_n.delete();
  endtask

  task automatic compare();
    bit en;
    en = exp_en();
    chk("pipe_en", 512'(pipe_en), 512'(en));
    if (en) chk("pipe_nonce", 512'(pipe_nonce), 512'(m_next));
    chk("busy", 512'(busy), 512'(m_state == 1 || m_state == 2));
    chk("done", 512'(done), 512'(m_done));
    chk("found", 512'(found), 512'(m_found));
    chk("golden_nonce", 512'(golden_nonce), 512'(m_golden));
    chk("aborted", 512'(aborted), 512'(m_aborted));
    chk("pipe_W", pipe_W, m_W);
    chk("pipe_H", 512'(pipe_H), 512'(m_H));
`ifdef NONCE_SCHED_STATS_EN
    chk("hash_cnt", 512'(hash_cnt), 512'(m_cnt[31:0]));
`endif
  endtask

  task automatic drive_res();
    res_valid = 1'b0;
    res_nonce = $urandom;
    res_hash  = {8{$urandom}};
    if (stray) begin
      res_valid = 1'b1;
      res_nonce = 32'hDEAD;
      res_hash  = '0;
    end else if (iq_n.size() > 0 && allow != 0 &&
                 cyc - iq_c[0] >= lat && $urandom_range(0, 3) < rthr) begin
      res_valid = 1'b1;
      res_nonce = iq_n[0];
      res_hash  = hashf(iq_n[0]);
    end
  endtask

  task automatic update();
    bit en, bsy, acc, hit;
    int sz0;
    logic [31:0] d;
    en  = exp_en();
    bsy = (m_state == 1 || m_state == 2);
    sz0 = iq_n.size();
    acc = res_valid && bsy && sz0 > 0;
    hit = acc && res_hash[255 -: ZB] == '0 && !m_found;
    m_done = 0;
    if (acc) begin
      void'(iq_c.pop_front());
      void'(iq_n.pop_front());
      if (allow > 0) allow--;
      if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
    end
    if (hit) begin
      m_found  = 1;
      m_golden = res_nonce;
    end
    if (abort && bsy) m_aborted = 1;
    if (en) begin
      iq_c.push_back(cyc); iq_n.push_back(m_next);
      log_c.push_back(cyc); log_n.push_back(m_next);
      m_next = m_next + 1;
      m_left--;
      m_last_iss = cyc;
    end
    case (m_state)
      0, 3: if (start) begin
        d = nonce_last - nonce_first;
        m_left = longint'(d) + 1;
        m_next = nonce_first;
        m_W = W_cfg; m_H = H_cfg;
        m_found = 0; m_aborted = 0; m_golden = '0; m_cnt = 0;
        m_last_iss = -1000;
        m_state = 1;
        start_cyc = cyc;
        log_c.delete(); log_n.delete();
      end
      1: if ((en && m_left == 0) || hit || abort) m_state = 2;
      2: if (sz0 == 0) begin m_state = 3; m_done = 1; end
      default: ;
    endcase
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    drive_res();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] f, input logic [31:0] l);
    nonce_first = f;
    nonce_last  = l;
    W_cfg = {16{$urandom}};
    H_cfg = {8{$urandom}};
    start = 1'b1;
    step();
    start = 1'b0;
    nonce_first = $urandom;
    nonce_last  = $urandom;
    W_cfg = {16{$urandom}};
    H_cfg = {8{$urandom}};
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (done) seen = 1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL wait_done: done=0 after %0d cycles, required 1", budget);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    nonce_first = '0; nonce_last = '0; W_cfg = '0; H_cfg = '0;
    res_valid = 1'b0; res_hash = '0; res_nonce = '0;
    allow = -1; lat = 3; rthr = 4; stray = 0; hit_on = 0;
    tgt1 = '0; tgt2 = '0;
    model_reset();
    #1;
    chk("rst_pipe_en", 512'(pipe_en), 512'(0));
    chk("rst_pipe_nonce", 512'(pipe_nonce), 512'(0));
    chk("rst_pipe_W", pipe_W, 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_found", 512'(found), 512'(0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // stray result while idle is ignored
    stray = 1; step(); stray = 0; step();

    // range 0x10..0x13, no hit
    pulse_start(32'h10, 32'h13);
    wait_done(200);
    chk("t1_issues", 512'(log_n.size()), 512'(4));
    for (int i = 0; i < 4 && i < log_n.size(); i++) begin
      chk("t1_issue_cycle", 512'(log_c[i] - start_cyc), 512'(1 + 4 * i));
      chk("t1_issue_nonce", 512'(log_n[i]), 512'(32'h10 + i));
    end
    chk("t1_found", 512'(found), 512'(0));
`ifdef NONCE_SCHED_STATS_EN
    chk("t1_hash_cnt", 512'(hash_cnt), 512'(4));
`endif
    stray = 1; step(); stray = 0; step();

    // range 0..0xFF, zero hash for 5 (and a later hit at 7 that must lose)
    hit_on = 1; tgt1 = 32'h5; tgt2 = 32'h7; lat = 10;
    pulse_start(32'h0, 32'hFF);
    wait_done(400);
    chk("t2_found", 512'(found), 512'(1));
    chk("t2_golden", 512'(golden_nonce), 512'(5));
    hit_on = 0; lat = 3;

    // wrap through 0xFFFFFFFF
    pulse_start(32'hFFFF_FFFE, 32'h1);
    wait_done(200);
    chk("t3_issues", 512'(log_n.size()), 512'(4));
    if (log_n.size() == 4) begin
      chk("t3_n0", 512'(log_n[0]), 512'(32'hFFFF_FFFE));
      chk("t3_n1", 512'(log_n[1]), 512'(32'hFFFF_FFFF));
      chk("t3_n2", 512'(log_n[2]), 512'(32'h0));
      chk("t3_n3", 512'(log_n[3]), 512'(32'h1));
    end

    // single-nonce range
    pulse_start(32'h77, 32'h77);
    wait_done(100);
    chk("t3b_issues", 512'(log_n.size()), 512'(1));

    // in-flight limit: results withheld, then one released
    allow = 0; lat = 1;
    pulse_start(32'h100, 32'h1FF);
    repeat (30) step();
    chk("t4_stall_issues", 512'(log_n.size()), 512'(MAXF));
    chk("t4_busy", 512'(busy), 512'(1));
    allow = 1;
    repeat (10) step();
    chk("t4_release_issues", 512'(log_n.size()), 512'(MAXF + 1));
    abort = 1; step(); abort = 0;
    allow = -1;
    wait_done(100);
    chk("t4_aborted", 512'(aborted), 512'(1));

    // abort with two in flight
    allow = 0;
    pulse_start(32'h200, 32'h2FF);
    repeat (5) step();
    abort = 1; step(); abort = 0;
    repeat (10) step();
    chk("t5_issues", 512'(log_n.size()), 512'(2));
    allow = -1;
    wait_done(100);
    chk("t5_aborted", 512'(aborted), 512'(1));
    chk("t5_found", 512'(found), 512'(0));

    // reset in DRAIN
    allow = 0;
    pulse_start(32'h300, 32'h301);
    repeat (10) step();
    chk("t6_busy_before", 512'(busy), 512'(1));
    reset = 1'b1;
    #1;
    chk("t6_busy", 512'(busy), 512'(0));
    chk("t6_found", 512'(found), 512'(0));
    chk("t6_pipe_en", 512'(pipe_en), 512'(0));
    chk("t6_done", 512'(done), 512'(0));
`ifdef NONCE_SCHED_STATS_EN
    chk("t6_hash_cnt", 512'(hash_cnt), 512'(0));
`endif
    model_reset();
    allow = -1;
    res_valid = 1'b0;
    @(negedge clk);
    chk("t6_done_in_reset", 512'(done), 512'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;
    cyc++;

    // random jobs
    for (int j = 0; j < 40; j++) begin
      logic [31:0] f;
      int len;
      bit seen;
      len = $urandom_range(0, 15);
      f = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7)
                                      : $urandom;
      hit_on = $urandom_range(0, 1);
      tgt1 = f + $urandom_range(0, len + 2);
      tgt2 = f + $urandom_range(0, len);
      lat  = $urandom_range(1, 12);
      rthr = $urandom_range(1, 4);
      pulse_start(f, f + len);
      seen = 0;
      for (int i = 0; i < 600 && !seen; i++) begin
        abort = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 29) == 0) begin
          start = 1'b1;
          nonce_first = $urandom;
          nonce_last  = nonce_first + 2;
        end
        step();
        abort = 1'b0;
        start = 1'b0;
        if (done) seen = 1;
      end
      tests++;
      if (!seen) begin
        fails++;
        $display("FAIL rand_job_done: done=0 in job %0d, required 1", j);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
